// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration in IDLE, then one SETUP/ACCESS
// transfer on the shared APB port with a registered per-requester completion strobe.
module apb_arb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  output logic                busy,
  output logic                PSEL1,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;
  logic              winner;
  logic              accept;

  // On a tie the requester not granted last time wins; otherwise the lone requester.
  always_comb begin
    if (req_valid == 2'b11) winner = ~last_q;
    else                    winner = ~req_valid[0];
  end

  assign accept    = (state_q == S_IDLE) && (|req_valid) && !rst;
  assign req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_SETUP;
          last_d   = winner;
          owner_d  = winner;
          psel_d   = 1'b1;
          pwrite_d = req_write[winner];
          paddr_d  = winner ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          pwdata_d = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        // Completer response is only looked at here; wait states are unbounded.
        if (PREADY) begin
          state_d      = S_IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
          rsp_rdata_d  = PRDATA;
          rsp_slverr_d = PSLVERR;
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign PSEL1      = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: transaction-level requester/completer model with
// round-robin prediction, directed scenarios, random traffic and APB protocol monitor.
module tb_apb_arb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0] PADDR;
  logic rsp_slverr, busy, PSEL1, PENABLE, PWRITE, PREADY, PSLVERR;

  always #5 clk = ~clk;

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .busy(busy), .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending request per requester, last grant, last response.
  bit          pend_v[2];
  bit          pend_w[2];
  logic [AW-1:0] pend_a[2];
  logic [DW-1:0] pend_d[2];
  int          m_last;
  logic [DW-1:0] m_rdata;
  bit          m_err;
  logic [1:0]  exp_rsp;
  logic [1:0]  obs_ready;
  bit          refill;

  function automatic int pick();
    if (pend_v[0] && pend_v[1]) return 1 - m_last;
    return pend_v[0] ? 0 : 1;
  endfunction

  task automatic new_req(input int i);
    pend_v[i] = 1'b1;
    pend_w[i] = 1'($urandom);
    pend_a[i] = $urandom;
    pend_d[i] = $urandom;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = pend_v[i];
      req_write[i] = pend_w[i];
      req_addr[i*AW +: AW]  = pend_a[i];
      req_wdata[i*DW +: DW] = pend_d[i];
    end
  endtask

  task automatic noise();
    PREADY  = 1'($urandom);
    PRDATA  = $urandom;
    PSLVERR = 1'($urandom);
  endtask

  task automatic model_reset();
    m_last = 1; m_rdata = '0; m_err = 1'b0; exp_rsp = 2'b00;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
  endtask

  // One complete transfer; starts in an IDLE cycle just after the edge, ends in the
  // completion cycle just after the edge (so the next call accepts back-to-back).
  task automatic run_xfer(input int waits, input logic [DW-1:0] rd, input bit err);
    int win;
    bit ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [69:0] got, exp;
    drive_reqs(); noise();
    @(negedge clk);
    win = pick();
    obs_ready = req_ready;
    n_chk++;
    if ({req_ready, busy, PSEL1, PENABLE} !== {(win == 1) ? 2'b10 : 2'b01, 3'b000}) begin
      n_fail++;
      $display("FAIL accept got ready=%b busy=%b psel=%b pen=%b exp ready=%0d-hot idle", req_ready, busy, PSEL1, PENABLE, win);
    end
    n_chk++;
    if ({rsp_valid, rsp_rdata, rsp_slverr} !== {exp_rsp, m_rdata, m_err}) begin
      n_fail++;
      $display("FAIL accept_rsp got %b/%h/%b exp %b/%h/%b", rsp_valid, rsp_rdata, rsp_slverr, exp_rsp, m_rdata, m_err);
    end
    exp_rsp = 2'b00;
    ew = pend_w[win]; ea = pend_a[win]; ed = pend_d[win];
    m_last = win; pend_v[win] = 1'b0;
    if (refill) new_req(win);
    @(posedge clk); #1;
    drive_reqs(); noise();
    @(negedge clk);
    got = {PSEL1, PENABLE, PWRITE, PADDR, PWDATA, busy, req_ready};
    exp = {1'b1, 1'b0, ew, ea, ed, 1'b1, 2'b00};
    n_chk++;
    if (got !== exp || rsp_valid !== 2'b00 || rsp_rdata !== m_rdata) begin
      n_fail++;
      $display("FAIL setup got %h rsp=%b exp %h rsp=00", got, rsp_valid, exp);
    end
    @(posedge clk); #1;
    for (int w = 0; w <= waits; w++) begin
      PREADY  = (w == waits);
      PRDATA  = (w == waits) ? rd : $urandom;
      PSLVERR = (w == waits) ? err : 1'($urandom);
      @(negedge clk);
      got = {PSEL1, PENABLE, PWRITE, PADDR, PWDATA, busy, req_ready};
      exp = {1'b1, 1'b1, ew, ea, ed, 1'b1, 2'b00};
      n_chk++;
      if (got !== exp || rsp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL access[%0d] got %h rsp=%b exp %h rsp=00", w, got, rsp_valid, exp);
      end
      @(posedge clk); #1;
    end
    m_rdata = rd; m_err = err;
    exp_rsp = (win == 1) ? 2'b10 : 2'b01;
    n_chk++;
    if ({rsp_valid, rsp_rdata, rsp_slverr, PSEL1, PENABLE, busy} !== {exp_rsp, rd, err, 3'b000}) begin
      n_fail++;
      $display("FAIL complete got %b/%h/%b psel=%b pen=%b busy=%b exp %b/%h/%b 0 0 0",
               rsp_valid, rsp_rdata, rsp_slverr, PSEL1, PENABLE, busy, exp_rsp, rd, err);
    end
  endtask

  task automatic idle_cycle();
    drive_reqs(); noise();
    @(negedge clk);
    n_chk++;
    if ({req_ready, busy, PSEL1, PENABLE, rsp_valid, rsp_rdata, rsp_slverr} !==
        {2'b00, 3'b000, exp_rsp, m_rdata, m_err}) begin
      n_fail++;
      $display("FAIL idle got ready=%b busy=%b psel=%b pen=%b rsp=%b/%h/%b exp 00 0 0 0 %b/%h/%b",
               req_ready, busy, PSEL1, PENABLE, rsp_valid, rsp_rdata, rsp_slverr, exp_rsp, m_rdata, m_err);
    end
    exp_rsp = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11; req_write = 2'b11; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    noise();
    @(posedge clk); #1;
    noise();
    @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_slverr, busy, PSEL1, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_fail++;
      $display("FAIL reset got ready=%b rsp=%b/%h/%b busy=%b psel=%b pen=%b pw=%b pa=%h pd=%h exp all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_slverr, busy, PSEL1, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive_reqs();
  endtask

  task automatic test_single_write();
    pend_v[0] = 1'b1; pend_w[0] = 1'b1; pend_a[0] = 32'h10; pend_d[0] = 32'hA5A5_0001;
    run_xfer(0, $urandom, 1'b0);
    n_chk++;
    if (obs_ready !== 2'b01) begin n_fail++; $display("FAIL single_write_grant got %b exp 01", obs_ready); end
    idle_cycle();
  endtask

  task automatic test_read_wait();
    pend_v[1] = 1'b1; pend_w[1] = 1'b0; pend_a[1] = 32'h20; pend_d[1] = $urandom;
    run_xfer(3, 32'hDEAD_BEEF, 1'b0);
    n_chk++;
    if (obs_ready !== 2'b10) begin n_fail++; $display("FAIL read_wait_grant got %b exp 10", obs_ready); end
    idle_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    test_reset();
    refill = 1'b1;
    new_req(0); new_req(1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      run_xfer(0, $urandom, 1'b0);
      n_chk++;
      if (obs_ready !== exp_g) begin n_fail++; $display("FAIL contention_grant[%0d] got %b exp %b", k, obs_ready, exp_g); end
    end
    refill = 1'b0;
    while (pend_v[0] || pend_v[1]) run_xfer(0, $urandom, 1'b0);
    idle_cycle();
  endtask

  task automatic test_error();
    new_req(0); pend_w[0] = 1'b1;
    run_xfer(0, $urandom, 1'b1);
    new_req(0);
    run_xfer(1, $urandom, 1'b0);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    new_req(0); pend_w[0] = 1'b1;
    drive_reqs(); noise();
    @(negedge clk);
    n_chk++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_accept got %b exp 01", req_ready); end
    pend_v[0] = 1'b0;
    @(posedge clk); #1;
    drive_reqs(); PREADY = 1'b0;
    @(posedge clk); #1;
    PREADY = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({PSEL1, PENABLE} !== 2'b11) begin n_fail++; $display("FAIL midrst_access got %b%b exp 11", PSEL1, PENABLE); end
    @(posedge clk); #1;
    rst = 1'b1; PREADY = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_rdata, rsp_slverr, busy, PSEL1, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs got rsp=%b/%h/%b busy=%b psel=%b pen=%b pw=%b pa=%h pd=%h exp all 0",
               rsp_valid, rsp_rdata, rsp_slverr, busy, PSEL1, PENABLE, PWRITE, PADDR, PWDATA);
    end
    model_reset();
    new_req(1); pend_w[1] = 1'b0;
    run_xfer(0, $urandom, 1'b0);
    n_chk++;
    if (obs_ready !== 2'b10) begin n_fail++; $display("FAIL midrst_regrant got %b exp 10", obs_ready); end
    idle_cycle();
  endtask

  task automatic test_random();
    refill = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++)
        if (!pend_v[i] && $urandom_range(0, 2) != 0) new_req(i);
      if (!pend_v[0] && !pend_v[1]) idle_cycle();
      else run_xfer($urandom_range(0, 4), $urandom, 1'($urandom));
    end
    while (pend_v[0] || pend_v[1]) run_xfer($urandom_range(0, 2), $urandom, 1'($urandom));
    idle_cycle();
  endtask

  // Protocol monitor running throughout, suspended around reset edges.
  logic pv_psel = 1'b0, pv_pen = 1'b0, pv_rdy = 1'b0, pv_rst = 1'b1, pv_rise = 1'b0, pv_w = 1'b0;
  logic [AW-1:0] pv_a = '0;
  logic [DW-1:0] pv_d = '0;
  always @(negedge clk) begin
    if (rst === 1'b0 && pv_rst === 1'b0) begin
      if (pv_rise) begin
        n_chk++;
        if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL mon_psel_then_penable got %b exp 1", PENABLE); end
      end
      if (pv_pen === 1'b0 && PENABLE === 1'b1) begin
        n_chk++;
        if ({pv_psel, PSEL1, PWRITE, PADDR, PWDATA} !== {2'b11, pv_w, pv_a, pv_d}) begin
          n_fail++;
          $display("FAIL mon_stable_at_penable got %b%b %b %h %h exp 11 %b %h %h", pv_psel, PSEL1, PWRITE, PADDR, PWDATA, pv_w, pv_a, pv_d);
        end
      end
      if (pv_pen === 1'b1 && PENABLE === 1'b0) begin
        n_chk++;
        if (pv_rdy !== 1'b1) begin n_fail++; $display("FAIL mon_penable_fall got past_pready=%b exp 1", pv_rdy); end
      end
    end
    pv_rise = (pv_psel === 1'b0 && PSEL1 === 1'b1);
    pv_psel = PSEL1; pv_pen = PENABLE; pv_rdy = PREADY; pv_rst = rst;
    pv_w = PWRITE; pv_a = PADDR; pv_d = PWDATA;
  end

  initial begin
    rst = 1'b1; refill = 1'b0;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    model_reset();
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_error();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
